write_cmd_pool: RTL and testbench
=================================

// Module: write_cmd_pool
// PURPOSE
//  Write-command staging FIFO between the host write channel and the DDR command scheduler.
//  - Accepts one {address, data} beat per cycle and holds up to DEPTH beats in arrival order.
//  - Presents the oldest beat to the scheduler.
//  - Flags when a full burst (per burst_size) is queued, and reports overflow/underflow misuse.
// PARAMETERS
//  DEPTH       8   number of beat entries (power of two, >=8)
//  LOG2_DEPTH  3   log2(DEPTH); pointer width
//  DATA_SIZE   64  width of wdata / pool_wdata
//  ADDR_SIZE   8   width of waddr / pool_waddr
// PORTS
//  clk           in   1          rising-edge clock
//  n_rst         in   1          asynchronous active-low reset
//  wstrobe       in   1          push wdata/waddr this cycle
//  write_issued  in   1          scheduler consumed head entry; pop one entry
//  burst_size    in   2          burst length code: 0=1, 1=2, 2=4, 3=8 beats
//  wdata         in   DATA_SIZE  write data beat
//  waddr         in   ADDR_SIZE  beat address
//  wfull         out  1          occupancy == DEPTH
//  werr          out  1          overflow/underflow error indication
//  wready        out  1          occupancy >= burst length
//  pool_wdata    out  DATA_SIZE  data of head (oldest) entry
//  pool_waddr    out  ADDR_SIZE  address of head entry
// BEHAVIOUR
//  - Storage: DEPTH x {ADDR_SIZE+DATA_SIZE} array.
//    Read/write pointers are LOG2_DEPTH bits and wrap modulo DEPTH.
//    Occupancy counter is LOG2_DEPTH+1 bits.
//  - Reset (n_rst=0, async): pointers, count, array and werr cleared.
//    Consequently wfull=0, wready=0, werr=0, pool_wdata=0, pool_waddr=0.
//  - Push: on posedge with wstrobe=1 and (count<DEPTH or write_issued=1), the beat is written at wptr,
//    then wptr++ and count++. The beat is visible at the head one cycle later when the FIFO was empty.
//  - Pop: on posedge with write_issued=1 and count>0, rptr++ and count--.
//  - Simultaneous push+pop: both happen and count is unchanged.
//    This holds when full: the pop frees the slot and the push is accepted.
//    When empty: the push is accepted, the pop is ignored and flagged as underflow.
//  - Overflow: wstrobe=1, count==DEPTH, write_issued=0 -> beat dropped, state unchanged, error event.
//  - Underflow: write_issued=1 with count==0 -> no state change, error event.
//  - werr: registered; high for exactly one cycle after each error event (see CONFIGURATION).
//  - pool_wdata/pool_waddr: combinational from the entry at rptr; forced to 0 when count==0.
//  - wfull = (count==DEPTH); combinational from registered count.
//  - wready = (count >= (1<<burst_size)); combinational, so a burst_size change takes effect the same cycle.
//  - Input values are not checked: duplicate or unordered addresses are stored as given.
//  - Latency: push to head output is 1 clock; pop to next head is 1 clock.
// CONFIGURATION
//  WCP_STICKY_ERR_EN
//   - Defined: werr is sticky. It sets on the first error event and stays 1 until n_rst.
//   - Undefined (default): werr is a one-cycle pulse per error event.
// TESTING
//  1. Reset -> wfull=0, werr=0, wready=0, pool_wdata=0, pool_waddr=0.
//  2. burst_size=0, push (0x8c, 0x20) -> next cycle pool_wdata=0x8c, pool_waddr=0x20, wready=1;
//     one write_issued -> empty, wready=0, outputs 0.
//  3. burst_size=1, push 8 consecutive beats data {1,88,49,294,245,123,204,34}, addr 7..0
//     -> wfull=1 after 8th; head = first beat.
//     A 9th push (0x8c, 0x07) -> werr=1 for 1 cycle, beat dropped, count stays 8.
//  4. From test 3, pop 4 -> head = 5th beat pushed, wfull=0, count=4, wready=1 (4>=2);
//     burst_size=3 -> wready=0.
//  5. burst_size=3, push 3 beats -> count=7, wready=0; pop 7 -> empty, no werr;
//     one extra write_issued on empty -> werr pulse, state unchanged.
//  6. Full FIFO, wstrobe and write_issued in same cycle -> count stays 8, wfull=1,
//     no werr, new beat at tail (wrapped wptr).

Source files
------------

// File: rtl/write_cmd_pool.sv
// write_cmd_pool
//   Write-command staging FIFO between the host write channel and the DDR
//   command scheduler. Holds up to DEPTH {address, data} beats in arrival
//   order and presents the oldest beat to the scheduler.
//
//   Ports
//     clk           rising-edge clock
//     n_rst         asynchronous active-low reset
//     wstrobe       push {waddr, wdata} this cycle
//     write_issued  scheduler consumed the head entry; pop one entry
//     burst_size    burst length code: 0=1, 1=2, 2=4, 3=8 beats
//     wdata, waddr  incoming beat
//     wfull         occupancy == DEPTH
//     werr          overflow/underflow indication (registered)
//     wready        occupancy >= burst length (combinational on burst_size)
//     pool_wdata    head entry data, 0 when empty
//     pool_waddr    head entry address, 0 when empty
//
//   Build option
//     WCP_STICKY_ERR_EN  defined: werr sets on the first error and holds
//                        until reset; undefined: one-cycle pulse per error.
module write_cmd_pool #(
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3,
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 wstrobe,
    input  logic                 write_issued,
    input  logic [1:0]           burst_size,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] waddr,
    output logic                 wfull,
    output logic                 werr,
    output logic                 wready,
    output logic [DATA_SIZE-1:0] pool_wdata,
    output logic [ADDR_SIZE-1:0] pool_waddr
);

    localparam int ENTRY_W = ADDR_SIZE + DATA_SIZE;
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH-1:0] rptr;
    logic [LOG2_DEPTH:0]   count;
    logic [LOG2_DEPTH:0]   burst_len;

    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;
    logic err_event;

    always_comb begin
        is_full  = (count == FULL_CNT);
        is_empty = (count == '0);
        do_pop   = write_issued && !is_empty;
        // A pop in the same cycle frees the slot, so a full pool still accepts.
        do_push  = wstrobe && (!is_full || write_issued);
        // Push+pop on empty: push lands, the pop is reported as underflow.
        err_event = (wstrobe && is_full && !write_issued) ||
                    (write_issued && is_empty);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem   <= '{default: '0};
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= {waddr, wdata};
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            werr <= 1'b0;
        else
`ifdef WCP_STICKY_ERR_EN
            werr <= werr | err_event;
`else
            werr <= err_event;
`endif
    end

    always_comb begin
        burst_len = (LOG2_DEPTH+1)'(1) << burst_size;
        wfull     = is_full;
        wready    = (count >= burst_len);
        if (is_empty) begin
            pool_wdata = '0;
            pool_waddr = '0;
        end else begin
            {pool_waddr, pool_wdata} = mem[rptr];
        end
    end

endmodule

// File: tb/tb_write_cmd_pool.sv
module tb_write_cmd_pool;

    logic        clk;
    logic        n_rst;
    logic        wstrobe;
    logic        write_issued;
    logic [1:0]  burst_size;
    logic [63:0] wdata;
    logic [7:0]  waddr;
    logic        wfull;
    logic        werr;
    logic        wready;
    logic [63:0] pool_wdata;
    logic [7:0]  pool_waddr;

    write_cmd_pool #(
        .DEPTH(8), .LOG2_DEPTH(3), .DATA_SIZE(64), .ADDR_SIZE(8)
    ) dut (
        .clk(clk), .n_rst(n_rst), .wstrobe(wstrobe), .write_issued(write_issued),
        .burst_size(burst_size), .wdata(wdata), .waddr(waddr),
        .wfull(wfull), .werr(werr), .wready(wready),
        .pool_wdata(pool_wdata), .pool_waddr(pool_waddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ws;
        bit          wi;
        logic [1:0]  bs;
        logic [63:0] d;
        logic [7:0]  a;
        bit          ef;
        bit          ee;
        bit          er;
        logic [63:0] pd;
        logic [7:0]  pa;
    } vec_t;

    vec_t          vecs[$];
    logic [71:0]   mq[$];      // scoreboard: {addr, data} expected at the head, oldest first
    bit            exp_err;
    int            tests = 0;
    int            fails = 0;

    function automatic vec_t mk(bit ws, bit wi, logic [1:0] bs, logic [63:0] d, logic [7:0] a,
                                bit ef, bit ee, bit er, logic [63:0] pd, logic [7:0] pa);
        vec_t v;
        v.ws = ws; v.wi = wi; v.bs = bs; v.d = d; v.a = a;
        v.ef = ef; v.ee = ee; v.er = er; v.pd = pd; v.pa = pa;
        return v;
    endfunction

    function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drive one cycle; the reference queue is updated with the same rules the
    // pool should follow, and every pop is checked against the scoreboard head.
    task automatic cycle(input bit ws, input bit wi, input logic [1:0] bs,
                         input logic [63:0] d, input logic [7:0] a);
        int n;
        bit acc;
        n = mq.size();
        wstrobe = ws; write_issued = wi; burst_size = bs; wdata = d; waddr = a;
        #1;
        if (wi && n > 0)
            check("pop_head", {pool_waddr, pool_wdata}, mq[0]);
        exp_err = (ws && n == 8 && !wi) || (wi && n == 0);
        acc = ws && (n < 8 || wi);
        if (wi && n > 0) void'(mq.pop_front());
        if (acc) mq.push_back({a, d});
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        int n;
        n = mq.size();
        check({tag, "_wfull"},  72'(wfull),  72'(n == 8));
        check({tag, "_werr"},   72'(werr),   72'(exp_err));
        check({tag, "_wready"}, 72'(wready), 72'(n >= (1 << burst_size)));
        check({tag, "_head"}, {pool_waddr, pool_wdata}, (n == 0) ? 72'h0 : mq[0]);
    endtask

    initial begin
        logic [63:0] d8[8];
        d8 = '{64'd1, 64'd88, 64'd49, 64'd294, 64'd245, 64'd123, 64'd204, 64'd34};

        // Tests 2-4 as a vector table (expected values from the pool's contract)
        vecs.push_back(mk(1, 0, 0, 64'h8c, 8'h20, 0, 0, 1, 64'h8c, 8'h20));
        vecs.push_back(mk(0, 1, 0, 64'h0,  8'h00, 0, 0, 0, 64'h0,  8'h00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 1, d8[i], 8'(7 - i), i == 7, 0, i >= 1, 64'd1, 8'd7));
        vecs.push_back(mk(1, 0, 1, 64'h8c, 8'h07, 1, 1, 1, 64'd1, 8'd7));
        vecs.push_back(mk(0, 0, 1, 64'h0,  8'h00, 1, 0, 1, 64'd1, 8'd7));
        vecs.push_back(mk(0, 1, 1, 64'h0, 8'h0, 0, 0, 1, 64'd88,  8'd6));
        vecs.push_back(mk(0, 1, 1, 64'h0, 8'h0, 0, 0, 1, 64'd49,  8'd5));
        vecs.push_back(mk(0, 1, 1, 64'h0, 8'h0, 0, 0, 1, 64'd294, 8'd4));
        vecs.push_back(mk(0, 1, 1, 64'h0, 8'h0, 0, 0, 1, 64'd245, 8'd3));
        vecs.push_back(mk(0, 0, 3, 64'h0, 8'h0, 0, 0, 0, 64'd245, 8'd3));

        n_rst = 1'b0; wstrobe = 0; write_issued = 0; burst_size = 0; wdata = '0; waddr = '0;
        exp_err = 0;
        #12;
        check("rst_wfull",  72'(wfull),  72'h0);
        check("rst_werr",   72'(werr),   72'h0);
        check("rst_wready", 72'(wready), 72'h0);
        check("rst_head",   {pool_waddr, pool_wdata}, 72'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].ws, vecs[i].wi, vecs[i].bs, vecs[i].d, vecs[i].a);
            check($sformatf("vec%0d_wfull", i),  72'(wfull),  72'(vecs[i].ef));
            check($sformatf("vec%0d_werr", i),   72'(werr),   72'(vecs[i].ee));
            check($sformatf("vec%0d_wready", i), 72'(wready), 72'(vecs[i].er));
            check($sformatf("vec%0d_head", i), {pool_waddr, pool_wdata}, {vecs[i].pa, vecs[i].pd});
        end

        // Test 5: top up to 7 at burst 8, drain, then underflow
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 3, 64'h100 + 64'(i), 8'hA0 + 8'(i));
            check_model("t5_push");
        end
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, 3, '0, '0);
            check_model("t5_pop");
        end
        cycle(0, 1, 3, '0, '0);
        check("underflow_werr", 72'(werr), 72'h1);
        check("underflow_head", {pool_waddr, pool_wdata}, 72'h0);
        cycle(0, 0, 3, '0, '0);
        check("underflow_werr_clear", 72'(werr), 72'h0);

        // Push+pop on empty: push lands, pop flagged
        cycle(1, 1, 0, 64'h55, 8'h33);
        check_model("empty_pp");
        check("empty_pp_werr", 72'(werr), 72'h1);
        cycle(0, 1, 0, '0, '0);
        check_model("empty_pp_drain");

        // Test 6: full with simultaneous push+pop, then drain through the wrap
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 2, {$urandom, $urandom}, 8'($urandom));
            check_model("t6_fill");
        end
        cycle(1, 1, 2, 64'hDEAD_BEEF_0000_0006, 8'h66);
        check_model("t6_pp");
        check("t6_pp_wfull", 72'(wfull), 72'h1);
        check("t6_pp_werr",  72'(werr),  72'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 2, '0, '0);
            check_model("t6_drain");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
